// File: rtl/bfm_apbslave_mem.sv
// APB3 slave memory model with configurable wait states and range error.
// Ports: HCLK/HRESET, APB slot (PSEL..PWDATA in; PRDATA/PREADY/PSLVERR out),
// XFER_CNT completed-transfer counter, PROT_ERR sticky protocol flag.
module bfm_apbslave_mem #(
    parameter int AWIDTH = 8,
    parameter int WAITS  = 0,
    parameter bit ERR_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [15:0] XFER_CNT,
    output logic        PROT_ERR
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [3:0] WAIT_LD = 4'(WAITS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e      state_q, state_d;
    logic [21:0] addr_q, addr_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] xfer_q, xfer_d;
    logic        prot_q, prot_d;
    logic        mem_we;

    logic [31:0] mem [DEPTH];

    logic [AWIDTH-1:0] widx;
    logic              oor;
    logic              acc_rdy;
    logic              viol;
    logic              rd_err;

    // Index wraps modulo DEPTH; range test uses the full latched word address.
    assign widx    = addr_q[AWIDTH-1:0];
    assign oor     = {10'd0, addr_q} >= 32'(DEPTH);
    assign acc_rdy = (state_q == ACCESS) && (wait_q == 4'd0);
    // Enable without a preceding setup phase is answered at once with an error.
    assign viol    = (state_q == IDLE) && PSEL && PENABLE;
    assign rd_err  = oor && ERR_EN && !PWRITE;

    assign PREADY   = acc_rdy || viol;
    assign PSLVERR  = (acc_rdy && oor && ERR_EN) || viol;
    assign PRDATA   = (acc_rdy && !rd_err) ? mem[widx] : 32'd0;
    assign XFER_CNT = xfer_q;
    assign PROT_ERR = prot_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        xfer_d  = xfer_q;
        prot_d  = prot_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR[23:2];
                    wait_d  = WAIT_LD;
                    state_d = ACCESS;
                end else if (PSEL && PENABLE) begin
                    prot_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Abort: drop the transfer without write or count.
                    prot_d  = 1'b1;
                    state_d = IDLE;
                end else if (!PENABLE) begin
                    // Fresh setup mid-access restarts the transfer.
                    prot_d = 1'b1;
                    addr_d = PADDR[23:2];
                    wait_d = WAIT_LD;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    mem_we  = PWRITE && !(oor && ERR_EN);
                    xfer_d  = xfer_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wait_q  <= '0;
            xfer_q  <= '0;
            prot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            xfer_q  <= xfer_d;
            prot_q  <= prot_d;
        end
    end

    // Storage is not reset; a reset edge only suppresses a pending write.
    always_ff @(posedge HCLK) begin
        if (mem_we && !HRESET) begin
            mem[widx] <= PWDATA;
        end
    end

endmodule
